// File: rtl/program_load_debug_ctrl_pkg.sv
// Shared definitions for the program-load / debug-execution controller:
// command byte values, FSM state encoding and the default end-of-program word.
package program_load_debug_ctrl_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN   = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_NEXT  = 8'h4E;  // 'N'
  localparam logic [7:0] CMD_PAUSE = 8'h50;  // 'P'

  localparam logic [31:0] DEFAULT_END_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    FINISH = 3'd2,
    RUN    = 3'd3,
    STEP   = 3'd4
  } state_t;

endpackage

// File: rtl/program_load_debug_ctrl_word_assembler.sv
// Big-endian 4-byte word assembler.
// Ports: clk, rst (sync, active high), clr (restart at byte 0),
//        byte_valid/byte_data (incoming byte),
//        word_c (word including the byte currently presented),
//        word_valid_c (high while the 4th byte of a word is presented).
module program_load_debug_ctrl_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word_c,
  output logic        word_valid_c
);

  logic [31:0] word;
  logic [1:0]  cnt;

  // Shift register and byte position counter
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word <= '0;
      cnt  <= '0;
    end else if (byte_valid) begin
      word <= word_c;
      cnt  <= cnt + 2'd1;
    end
  end

  assign word_c       = {word[23:0], byte_data};
  assign word_valid_c = byte_valid && (cnt == 2'd3);

endmodule

// File: rtl/program_load_debug_ctrl.sv
// Program-download and debug-execution controller for the fetch stage.
// Assembles UART bytes into instruction words, writes them through the
// program-load port, then gates execution (run / single step) via stop_debug.
// Ports: clk, rst (sync, active high), rx_data/rx_valid (UART bytes),
//        halt_detected (pipeline retired HALT), load_program/prog_addr/
//        prog_data/prog_wr (imem write port), stop_debug, pipe_rst, done,
//        error, word_count, step_count, state (debug readout).
module program_load_debug_ctrl
  import program_load_debug_ctrl_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter logic [31:0] END_WORD  = DEFAULT_END_WORD,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              halt_detected,
  output logic              load_program,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [31:0]       prog_data,
  output logic              prog_wr,
  output logic              stop_debug,
  output logic              pipe_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] word_count,
  output logic [31:0]       step_count,
  output logic [2:0]        state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  state_t            st, st_nxt;
  logic              loaded, loaded_nxt;
  logic              load_nxt, wr_nxt, stop_nxt, pipe_nxt, done_nxt, err_nxt;
  logic [ADDR_W-1:0] addr_nxt, wc_nxt;
  logic [31:0]       data_nxt, sc_nxt;
  logic              clr_c;
  logic [31:0]       asm_word_c;
  logic              asm_valid_c;
  logic              cmd_l, cmd_r, cmd_s, cmd_n, cmd_p;

  assign cmd_l = rx_valid && (rx_data == CMD_LOAD);
  assign cmd_r = rx_valid && (rx_data == CMD_RUN);
  assign cmd_s = rx_valid && (rx_data == CMD_STEP);
  assign cmd_n = rx_valid && (rx_data == CMD_NEXT);
  assign cmd_p = rx_valid && (rx_data == CMD_PAUSE);

  // Bytes only reach the assembler while loading
  program_load_debug_ctrl_word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr_c),
    .byte_valid   (rx_valid && (st == LOAD)),
    .byte_data    (rx_data),
    .word_c       (asm_word_c),
    .word_valid_c (asm_valid_c)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= IDLE;
      loaded       <= 1'b0;
      load_program <= 1'b0;
      prog_addr    <= '0;
      prog_data    <= '0;
      prog_wr      <= 1'b0;
      stop_debug   <= 1'b1;
      pipe_rst     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      word_count   <= '0;
      step_count   <= '0;
    end else begin
      st           <= st_nxt;
      loaded       <= loaded_nxt;
      load_program <= load_nxt;
      prog_addr    <= addr_nxt;
      prog_data    <= data_nxt;
      prog_wr      <= wr_nxt;
      stop_debug   <= stop_nxt;
      pipe_rst     <= pipe_nxt;
      done         <= done_nxt;
      error        <= err_nxt;
      word_count   <= wc_nxt;
      step_count   <= sc_nxt;
    end
  end

  assign state = st;

  // Next-state and next-output logic
  always_comb begin
    st_nxt     = st;
    loaded_nxt = loaded;
    load_nxt   = load_program;
    addr_nxt   = prog_addr;
    data_nxt   = prog_data;
    wr_nxt     = 1'b0;
    stop_nxt   = 1'b1;
    pipe_nxt   = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = error;
    wc_nxt     = word_count;
    sc_nxt     = step_count;
    clr_c      = 1'b0;

    case (st)
      IDLE: begin
        if (cmd_l) begin
          st_nxt     = LOAD;
          load_nxt   = 1'b1;
          addr_nxt   = '0;
          err_nxt    = 1'b0;
          wc_nxt     = '0;
          sc_nxt     = '0;
          loaded_nxt = 1'b0;
          clr_c      = 1'b1;
        end else if (cmd_r && loaded) begin
          st_nxt   = RUN;
          stop_nxt = 1'b0;
        end else if (cmd_s && loaded) begin
          st_nxt = STEP;
        end
      end

      LOAD: begin
        if (asm_valid_c) begin
          wr_nxt   = 1'b1;
          data_nxt = asm_word_c;
        end
        // Post-write bookkeeping happens at the end of the write cycle so the
        // address stays stable while prog_wr is high.
        if (prog_wr) begin
          wc_nxt = word_count + ADDR_W'(1);
          if (prog_data == END_WORD) begin
            st_nxt     = FINISH;
            load_nxt   = 1'b0;
            pipe_nxt   = 1'b1;
            loaded_nxt = 1'b1;
          end else if (prog_addr == LAST_ADDR) begin
            st_nxt     = IDLE;
            load_nxt   = 1'b0;
            err_nxt    = 1'b1;
            loaded_nxt = 1'b0;
          end else begin
            addr_nxt = prog_addr + ADDR_W'(1);
          end
        end
      end

      FINISH: st_nxt = IDLE;

      RUN: begin
        if (halt_detected) begin
          st_nxt   = IDLE;
          done_nxt = 1'b1;
        end else if (cmd_p) begin
          st_nxt = STEP;
        end else begin
          stop_nxt = 1'b0;
        end
      end

      STEP: begin
        if (halt_detected) begin
          st_nxt   = IDLE;
          done_nxt = 1'b1;
        end else if (cmd_r) begin
          st_nxt   = RUN;
          stop_nxt = 1'b0;
        end else if (cmd_n && stop_debug) begin
          // stop_debug low means a step pulse is in flight; 'N' then ignored
          stop_nxt = 1'b0;
          sc_nxt   = step_count + 32'd1;
        end
      end

      default: st_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_program_load_debug_ctrl.sv
// Self-checking bench for program_load_debug_ctrl (MEM_DEPTH = 4 instance).
module tb_program_load_debug_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_RUN = 3'd3, S_STEP = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        halt_detected;
  logic        load_program;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        prog_wr;
  logic        stop_debug;
  logic        pipe_rst;
  logic        done;
  logic        error;
  logic [31:0] word_count;
  logic [31:0] step_count;
  logic [2:0]  state;

  program_load_debug_ctrl #(.MEM_DEPTH(4), .END_WORD(32'hFFFF_FFFF), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .halt_detected (halt_detected),
    .load_program  (load_program),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
    .prog_wr       (prog_wr),
    .stop_debug    (stop_debug),
    .pipe_rst      (pipe_rst),
    .done          (done),
    .error         (error),
    .word_count    (word_count),
    .step_count    (step_count),
    .state         (state)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] word; logic [31:0] addr; } load_vec_t;
  typedef struct { logic [7:0] cmd; logic [2:0] exp_state; logic exp_stop; } cmd_vec_t;

  wr_t       exp_q[$];
  wr_t       e;
  logic [7:0] bq[$];
  int        total = 0;
  int        passed = 0;
  int        low_cnt = 0;
  int        pipe_cnt = 0;
  int        done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Write scoreboard and pulse counters
  always @(negedge clk) begin
    if (stop_debug === 1'b0) low_cnt++;
    if (pipe_rst === 1'b1) pipe_cnt++;
    if (done === 1'b1) done_cnt++;
    if (prog_wr === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("wr_addr", prog_addr, e.addr);
        check("wr_data", prog_data, e.data);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Back-to-back bytes, one per cycle, from bq
  task automatic send_stream();
    @(posedge clk); #1;
    while (bq.size() > 0) begin
      rx_data = bq.pop_front(); rx_valid = 1'b1;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic queue_word(input logic [31:0] w, input logic [31:0] a);
    bq.push_back(w[31:24]); bq.push_back(w[23:16]);
    bq.push_back(w[15:8]);  bq.push_back(w[7:0]);
    exp_q.push_back('{addr: a, data: w});
  endtask

  task automatic pulse_halt();
    @(posedge clk); #1 halt_detected = 1'b1;
    @(posedge clk); #1 halt_detected = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  load_vec_t load_tab[3];
  cmd_vec_t  cmd_tab[10];
  int        base, bad;

  initial begin
    load_tab[0] = '{32'h0000_002A, 32'd0};
    load_tab[1] = '{32'h1234_5678, 32'd1};
    load_tab[2] = '{32'hFFFF_FFFF, 32'd2};

    cmd_tab[0] = '{8'h41,      S_IDLE, 1'b1};
    cmd_tab[1] = '{8'h4E,      S_IDLE, 1'b1};
    cmd_tab[2] = '{8'h50,      S_IDLE, 1'b1};
    cmd_tab[3] = '{8'h53,      S_STEP, 1'b1};
    cmd_tab[4] = '{8'h4E,      S_STEP, 1'b0};
    cmd_tab[5] = '{8'h41,      S_STEP, 1'b1};
    cmd_tab[6] = '{8'h52,      S_RUN,  1'b0};
    cmd_tab[7] = '{8'h50,      S_STEP, 1'b1};
    cmd_tab[8] = '{8'h4C,      S_STEP, 1'b1};
    cmd_tab[9] = '{8'h4E,      S_STEP, 1'b0};

    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; halt_detected = 1'b0;
    wait_cycles(3);
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_stop", 32'(stop_debug), 32'd1);
    check("rst_load_program", 32'(load_program), 32'd0);
    check("rst_prog_addr", prog_addr, 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_word_count", word_count, 32'd0);
    rst = 1'b0;

    // Run/step before anything is loaded is ignored
    send_byte(8'h52);
    check("unloaded_R_state", 32'(state), 32'(S_IDLE));
    check("unloaded_R_stop", 32'(stop_debug), 32'd1);

    // Table-driven program load with back-to-back bytes
    base = pipe_cnt;
    send_byte(8'h4C);
    check("L_state", 32'(state), 32'(S_LOAD));
    check("L_load_program", 32'(load_program), 32'd1);
    for (int i = 0; i < 3; i++) queue_word(load_tab[i].word, load_tab[i].addr);
    send_stream();
    wait_cycles(3);
    check("load_q_empty", 32'(exp_q.size()), 32'd0);
    check("load_done_state", 32'(state), 32'(S_IDLE));
    check("load_program_off", 32'(load_program), 32'd0);
    check("load_word_count", word_count, 32'd3);
    check("load_pipe_rst_cycles", 32'(pipe_cnt - base), 32'd1);
    check("load_last_addr", prog_addr, 32'd2);
    check("load_stop_held", 32'(stop_debug), 32'd1);

    // Continuous run then HALT
    base = done_cnt;
    send_byte(8'h52);
    check("run_state", 32'(state), 32'(S_RUN));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (stop_debug !== 1'b0) bad++;
    end
    check("run_stop_low_cycles_bad", 32'(bad), 32'd0);
    pulse_halt();
    check("halt_state", 32'(state), 32'(S_IDLE));
    check("halt_stop", 32'(stop_debug), 32'd1);
    check("halt_done", 32'(done), 32'd1);
    wait_cycles(2);
    check("halt_done_pulses", 32'(done_cnt - base), 32'd1);

    // Single step: three 'N' spaced apart
    base = low_cnt;
    send_byte(8'h53);
    check("step_state", 32'(state), 32'(S_STEP));
    for (int i = 0; i < 3; i++) begin
      wait_cycles(4);
      send_byte(8'h4E);
    end
    wait_cycles(3);
    check("step_low_cycles", 32'(low_cnt - base), 32'd3);
    check("step_count3", step_count, 32'd3);
    pulse_halt();
    check("step_halt_state", 32'(state), 32'(S_IDLE));
    check("step_halt_done", 32'(done), 32'd1);

    // Table-driven command handling
    for (int i = 0; i < 10; i++) begin
      send_byte(cmd_tab[i].cmd);
      check($sformatf("cmd%0d_state", i), 32'(state), 32'(cmd_tab[i].exp_state));
      check($sformatf("cmd%0d_stop", i), 32'(stop_debug), 32'(cmd_tab[i].exp_stop));
    end
    check("cmd_step_count", step_count, 32'd5);

    // 'N' while the step pulse is active is ignored
    @(posedge clk); #1 rx_data = 8'h4E; rx_valid = 1'b1;
    @(posedge clk); #1;
    check("n_pulse_stop", 32'(stop_debug), 32'd0);
    @(posedge clk); #1 rx_valid = 1'b0;
    check("n_busy_stop", 32'(stop_debug), 32'd1);
    check("n_busy_count", step_count, 32'd6);

    // Pause and halt together: halt wins
    send_byte(8'h52);
    @(posedge clk); #1 rx_data = 8'h50; rx_valid = 1'b1; halt_detected = 1'b1;
    @(posedge clk); #1 rx_valid = 1'b0; halt_detected = 1'b0;
    check("ph_state", 32'(state), 32'(S_IDLE));
    check("ph_done", 32'(done), 32'd1);
    check("ph_stop", 32'(stop_debug), 32'd1);

    // Reset mid-word
    send_byte(8'h4C);
    check("reload_step_count", step_count, 32'd0);
    bq.push_back(8'hAA); bq.push_back(8'hBB);
    send_stream();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("mid_rst_state", 32'(state), 32'(S_IDLE));
    check("mid_rst_load_program", 32'(load_program), 32'd0);
    check("mid_rst_wr", 32'(prog_wr), 32'd0);
    check("mid_rst_stop", 32'(stop_debug), 32'd1);
    check("mid_rst_word_count", word_count, 32'd0);
    send_byte(8'h52);
    check("mid_rst_R_ignored", 32'(state), 32'(S_IDLE));
    base = pipe_cnt;
    send_byte(8'h4C);
    queue_word(32'hCAFE_BABE, 32'd0);
    queue_word(32'hFFFF_FFFF, 32'd1);
    send_stream();
    wait_cycles(3);
    check("reload_q_empty", 32'(exp_q.size()), 32'd0);
    check("reload_word_count", word_count, 32'd2);
    check("reload_pipe_rst", 32'(pipe_cnt - base), 32'd1);

    // Overflow: four non-END words into a 4-word memory
    base = pipe_cnt;
    send_byte(8'h4C);
    for (int i = 0; i < 4; i++) queue_word(32'h0101_0101 * (i + 1), 32'(i));
    send_stream();
    wait_cycles(3);
    check("ovf_q_empty", 32'(exp_q.size()), 32'd0);
    check("ovf_error", 32'(error), 32'd1);
    check("ovf_state", 32'(state), 32'(S_IDLE));
    check("ovf_load_program", 32'(load_program), 32'd0);
    check("ovf_word_count", word_count, 32'd4);
    check("ovf_addr", prog_addr, 32'd3);
    check("ovf_no_pipe_rst", 32'(pipe_cnt - base), 32'd0);
    send_byte(8'h52);
    check("ovf_R_state", 32'(state), 32'(S_IDLE));
    check("ovf_R_stop", 32'(stop_debug), 32'd1);
    send_byte(8'h4C);
    check("ovf_L_clears_error", 32'(error), 32'd0);
    check("ovf_L_state", 32'(state), 32'(S_LOAD));

    wait_cycles(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/program_load_debug_ctrl.md
Name: program_load_debug_ctrl

Overview:
Controller that sequences the instruction-fetch stage for program download and debug execution. It receives a byte stream from the UART receiver, assembles 32-bit instruction words and writes them into instruction memory through the fetch stage's program-load port. It then gates pipeline execution in continuous-run or single-step mode via the stop signal, until the pipeline reports a HALT.

Parameters:
MEM_DEPTH, 256, instruction memory depth in words; maximum loadable program length.
END_WORD, 32'hFFFFFFFF, end-of-program marker word; it is written to memory like any other word.
ADDR_W, 32, width of prog_addr.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous active-high reset.
rx_data  in  8  received byte.
rx_valid  in  1  one-cycle strobe qualifying rx_data; no backpressure.
halt_detected  in  1  pipeline has retired a HALT instruction; level or pulse.
load_program  out  1  selects prog_addr as the instruction-memory address.
prog_addr  out  ADDR_W  instruction-memory write address.
prog_data  out  32  instruction word to write.
prog_wr  out  1  one-cycle instruction-memory write enable.
stop_debug  out  1  1 freezes PC and IF/ID; 0 lets the pipeline advance.
pipe_rst  out  1  one-cycle pipeline reset pulse after a completed load.
done  out  1  one-cycle pulse when execution halts.
error  out  1  sticky load-overflow flag; cleared by the next 'L' command.
word_count  out  ADDR_W  words written by the last load, including END_WORD.
step_count  out  32  steps issued since the last load.
state  out  3  current FSM state, for debug readout.

Behaviour:
- All outputs registered. Reset values: state=IDLE, stop_debug=1, all other outputs 0, internal loaded flag=0, byte counter=0.
- Command bytes: 'L'=0x4C load, 'R'=0x52 run, 'S'=0x53 step mode, 'N'=0x4E next step, 'P'=0x50 pause.
- Unlisted bytes are ignored in every non-LOAD state. Bytes arriving in any state not listed below are also ignored.
- IDLE:
  - 'L': go to LOAD; load_program=1; prog_addr=0; byte counter=0; error=0; word_count=0; step_count=0; loaded=0.
  - 'R' with loaded=1: go to RUN.
  - 'S' with loaded=1: go to STEP.
  - 'R' or 'S' with loaded=0: ignored.
- LOAD, byte assembly:
  - Each rx_valid shifts the byte in big-endian order: word <= {word[23:0], rx_data}; counter increments modulo 4.
  - On the 4th byte, the next cycle has prog_wr=1 and prog_data=assembled word at the current prog_addr. Write latency is 1 cycle after the 4th strobe.
  - A byte arriving in the same cycle as prog_wr is accepted as byte 0 of the next word and is never lost.
- LOAD, after each write:
  - word_count increments.
  - If word==END_WORD: go to FINISH.
  - Else if prog_addr==MEM_DEPTH-1: error=1, load_program=0, loaded=0, go to IDLE. No pipe_rst in this case.
  - Else: prog_addr increments and state stays in LOAD.
- FINISH (1 cycle): load_program=0, pipe_rst=1 for exactly 1 cycle, loaded=1, stop_debug stays 1, then go to IDLE.
- RUN:
  - stop_debug=0 on the cycle after entry.
  - halt_detected: stop_debug=1 next cycle, done pulse, go to IDLE.
  - 'P': stop_debug=1, go to STEP.
  - halt_detected and 'P' in the same cycle: halt wins.
- STEP:
  - stop_debug=1 by default.
  - 'N': stop_debug=0 for exactly one clk cycle (one PC/IF-ID update), step_count increments, then back to 1.
  - 'R': go to RUN.
  - halt_detected: done pulse, go to IDLE.
  - 'N' arriving while the previous step pulse is active is ignored.
- loaded=1 persists across runs, so a program can be re-run without reloading.
- 'L' is only honoured in IDLE.
- rst in any state, including mid-word in LOAD, returns to reset values. A partial word is discarded and nothing is written.
- prog_addr never exceeds MEM_DEPTH-1.

Decomposition:
- Shared package holds:
  - command byte constants (CMD_LOAD, CMD_RUN, CMD_STEP, CMD_NEXT, CMD_PAUSE);
  - state encoding (IDLE, LOAD, FINISH, RUN, STEP);
  - default END_WORD.
- One natural sub-module, word_assembler: 4-byte big-endian shift register plus 2-bit counter, outputs word and word_valid. It is cleared by rst or by a load start.

Test Plan:
- 'L' then bytes 00 00 00 2A, 12 34 56 78, FF FF FF FF -> prog_wr pulses at addr 0,1,2 with data 0x0000002A, 0x12345678, 0xFFFFFFFF; one pipe_rst pulse; word_count=3; load_program back to 0.
- After load, 'R' then halt_detected asserted 20 cycles later -> stop_debug=0 for those cycles, then 1; one done pulse; state=IDLE.
- 'S' then 'N' three times spaced 5 cycles apart -> exactly three single-cycle stop_debug=0 pulses; step_count=3.
- MEM_DEPTH=4, load 4 non-END words -> error=1 after 4th write; no pipe_rst; subsequent 'R' ignored with stop_debug staying 1.
- rst asserted after 2 bytes of a word -> no prog_wr; all outputs at reset values the next cycle; a new 'L' loads from addr 0.
- In RUN, 'P' and halt_detected in the same cycle -> done pulse and state=IDLE, not STEP.
